// File: rtl/loop_gain_scheduler.sv
// ----------------------------------------------------------------------------
// loop_gain_scheduler
//
// Schedules the proportional and integral gain shifts of a PLL loop filter.
// The loop starts out wide (ACQUIRE), narrows once the phase error stays
// inside the lock window (SETTLE), and narrows again when fully locked
// (TRACK). A sustained large error in TRACK drops back to ACQUIRE. Every
// transition back towards acquisition clears the loop-filter integrator.
//
// Optional feature (macro LOOP_GAIN_SCHEDULER_TIMEOUT_EN): an acquisition
// watchdog restarts ACQUIRE when ACQUIRE+SETTLE last TIMEOUT cycles without
// reaching TRACK. When the macro is undefined, no watchdog logic is built.
//
// Ports:
//   gen_clk_i    in   generated-clock domain clock
//   reset_i      in   asynchronous, active-high reset
//   enable_i     in   loop enable; low forces IDLE
//   error_i      in   signed phase error, sampled every cycle
//   kp_shift_o   out  proportional gain right-shift
//   ki_shift_o   out  integral gain right-shift
//   integ_clr_o  out  one-cycle integrator clear pulse
//   lock_o       out  high while in TRACK
//   state_o      out  IDLE=00, ACQUIRE=01, SETTLE=10, TRACK=11
// ----------------------------------------------------------------------------
module loop_gain_scheduler #(
   parameter int unsigned ERROR_WIDTH   = 8,
   parameter int unsigned LOCK_THRESH   = 4,
   parameter int unsigned LOCK_COUNT    = 16,
   parameter int unsigned UNLOCK_THRESH = 32,
   parameter int unsigned UNLOCK_COUNT  = 4,
   parameter int unsigned TIMEOUT       = 1024
) (
   input  logic                          gen_clk_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic signed [ERROR_WIDTH-1:0] error_i,
   output logic [1:0]                    kp_shift_o,
   output logic [1:0]                    ki_shift_o,
   output logic                          integ_clr_o,
   output logic                          lock_o,
   output logic [1:0]                    state_o
);

   localparam logic [1:0] StIdle    = 2'b00;
   localparam logic [1:0] StAcquire = 2'b01;
   localparam logic [1:0] StSettle  = 2'b10;
   localparam logic [1:0] StTrack   = 2'b11;

   localparam int unsigned MaxCount = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int unsigned CntW     = $clog2(MaxCount + 1);

   localparam logic [CntW-1:0] CntOne     = CntW'(1);
   localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_COUNT - 1);
   localparam logic [CntW-1:0] UnlockLast = CntW'(UNLOCK_COUNT - 1);

   localparam logic [ERROR_WIDTH-1:0] ErrOne = ERROR_WIDTH'(1);
   localparam logic [ERROR_WIDTH-1:0] ErrMin = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
   localparam logic [ERROR_WIDTH-1:0] ErrMax = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

   logic [1:0]             r_state;
   logic [CntW-1:0]        r_cnt;
   logic [1:0]             r_kp;
   logic [1:0]             r_ki;
   logic                   r_clr;
   logic                   r_lock;

   logic [1:0]             w_state_nxt;
   logic [CntW-1:0]        w_cnt_nxt;
   logic                   w_clr_nxt;
   logic [1:0]             w_kp_nxt;
   logic [1:0]             w_ki_nxt;

   logic [ERROR_WIDTH-1:0] w_err_u;
   logic [ERROR_WIDTH-1:0] w_err_neg;
   logic [ERROR_WIDTH-1:0] w_abs;
   logic                   w_in_window;
   logic                   w_out_lock;
   logic                   w_lock_done;
   logic                   w_wd_expire;

   // Saturating magnitude: the most negative code has no positive twin.
   assign w_err_u   = error_i;
   assign w_err_neg = ~w_err_u + ErrOne;
   assign w_abs     = !w_err_u[ERROR_WIDTH-1] ? w_err_u :
                      (w_err_u == ErrMin)     ? ErrMax  : w_err_neg;

   assign w_in_window = (32'(w_abs) <= LOCK_THRESH);
   assign w_out_lock  = (32'(w_abs) >  UNLOCK_THRESH);
   assign w_lock_done = w_in_window && (r_cnt == LockLast);

`ifdef LOOP_GAIN_SCHEDULER_TIMEOUT_EN
   localparam int unsigned     WdW    = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0]  WdOne  = WdW'(1);
   localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);

   logic [WdW-1:0] r_wd;
   logic [WdW-1:0] w_wd_nxt;
   logic           w_in_acq;

   assign w_in_acq    = (r_state == StAcquire) || (r_state == StSettle);
   assign w_wd_expire = w_in_acq && (r_wd == WdLast);

   always_comb begin
      w_wd_nxt = r_wd;
      // Expiry either restarts acquisition or is pre-empted by TRACK/IDLE;
      // all three cases start the watchdog from zero.
      if (w_wd_expire || (w_state_nxt == StIdle) || (w_state_nxt == StTrack)) begin
         w_wd_nxt = '0;
      end else if (w_in_acq) begin
         w_wd_nxt = r_wd + WdOne;
      end
   end

   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wd <= '0;
      end else begin
         r_wd <= w_wd_nxt;
      end
   end
`else
   assign w_wd_expire = 1'b0;
`endif

   // Next-state logic; disabling the loop overrides everything else.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_nxt   = 1'b0;
      if (r_state == StIdle) begin
         if (enable_i) begin
            w_state_nxt = StAcquire;
            w_clr_nxt   = 1'b1;
            w_cnt_nxt   = '0;
         end
      end else if (!enable_i) begin
         w_state_nxt = StIdle;
         w_clr_nxt   = 1'b1;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            StAcquire, StSettle: begin
               // Reaching TRACK wins over a coincident watchdog expiry.
               if (w_lock_done && (r_state == StSettle)) begin
                  w_state_nxt = StTrack;
                  w_cnt_nxt   = '0;
               end else if (w_wd_expire) begin
                  w_state_nxt = StAcquire;
                  w_clr_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
               end else if (w_lock_done) begin
                  w_state_nxt = StSettle;
                  w_cnt_nxt   = '0;
               end else if (w_in_window) begin
                  w_cnt_nxt = r_cnt + CntOne;
               end else begin
                  w_cnt_nxt = '0;
               end
            end
            StTrack: begin
               if (w_out_lock) begin
                  if (r_cnt == UnlockLast) begin
                     w_state_nxt = StAcquire;
                     w_clr_nxt   = 1'b1;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + CntOne;
                  end
               end else begin
                  w_cnt_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Gains are decoded from the next state so they register with it.
   always_comb begin
      w_kp_nxt = 2'd0;
      w_ki_nxt = 2'd0;
      case (w_state_nxt)
         StSettle: begin
            w_kp_nxt = 2'd1;
            w_ki_nxt = 2'd1;
         end
         StTrack: begin
            w_kp_nxt = 2'd2;
            w_ki_nxt = 2'd3;
         end
         default: begin
            w_kp_nxt = 2'd0;
            w_ki_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_kp    <= 2'd0;
         r_ki    <= 2'd0;
         r_clr   <= 1'b0;
         r_lock  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_kp    <= w_kp_nxt;
         r_ki    <= w_ki_nxt;
         r_clr   <= w_clr_nxt;
         r_lock  <= (w_state_nxt == StTrack);
      end
   end

   assign kp_shift_o  = r_kp;
   assign ki_shift_o  = r_ki;
   assign integ_clr_o = r_clr;
   assign lock_o      = r_lock;
   assign state_o     = r_state;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// ----------------------------------------------------------------------------
// tb_loop_gain_scheduler
//
// Self-checking bench for loop_gain_scheduler: directed scenarios followed by
// randomized error bursts, all compared every cycle against a behavioural
// model of the gain schedule. Define LOOP_GAIN_SCHEDULER_TIMEOUT_EN for both
// bench and design to exercise the acquisition watchdog.
// ----------------------------------------------------------------------------
module tb_loop_gain_scheduler;

   localparam int LockTh   = 4;
   localparam int LockCnt  = 16;
   localparam int UnlockTh = 32;
   localparam int UnlockCnt = 4;
   localparam int Timeout  = 64;

   logic              gen_clk_i = 1'b0;
   logic              reset_i;
   logic              enable_i;
   logic signed [7:0] error_i;
   logic [1:0]        kp_shift_o;
   logic [1:0]        ki_shift_o;
   logic              integ_clr_o;
   logic              lock_o;
   logic [1:0]        state_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: stage 0..3 = IDLE/ACQUIRE/SETTLE/TRACK
   int m_stage;
   int m_run;
   int m_wd;
   int m_clr;
   int kp_tab[4] = '{0, 0, 1, 2};
   int ki_tab[4] = '{0, 0, 1, 3};

   loop_gain_scheduler #(
      .ERROR_WIDTH   (8),
      .LOCK_THRESH   (LockTh),
      .LOCK_COUNT    (LockCnt),
      .UNLOCK_THRESH (UnlockTh),
      .UNLOCK_COUNT  (UnlockCnt),
      .TIMEOUT       (Timeout)
   ) dut (
      .gen_clk_i   (gen_clk_i),
      .reset_i     (reset_i),
      .enable_i    (enable_i),
      .error_i     (error_i),
      .kp_shift_o  (kp_shift_o),
      .ki_shift_o  (ki_shift_o),
      .integ_clr_o (integ_clr_o),
      .lock_o      (lock_o),
      .state_o     (state_o)
   );

   always #5 gen_clk_i = ~gen_clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int magnitude(input int e);
      int a;
      a = (e < 0) ? -e : e;
      return (a > 127) ? 127 : a;
   endfunction

   task automatic model_reset();
      m_stage = 0;
      m_run   = 0;
      m_wd    = 0;
      m_clr   = 0;
   endtask

   task automatic model_edge(input bit en, input int e);
      int  a;
      bit  in_win;
      bit  out_lock;
      bit  done;
      a        = magnitude(e);
      in_win   = (a <= LockTh);
      out_lock = (a > UnlockTh);
      m_clr    = 0;
      if (m_stage == 0) begin
         if (en) begin
            m_stage = 1; m_clr = 1; m_run = 0; m_wd = 0;
         end
      end else if (!en) begin
         m_stage = 0; m_clr = 1; m_run = 0; m_wd = 0;
      end else if (m_stage == 3) begin
         m_run = out_lock ? m_run + 1 : 0;
         if (m_run == UnlockCnt) begin
            m_stage = 1; m_clr = 1; m_run = 0; m_wd = 0;
         end
      end else begin
         m_run = in_win ? m_run + 1 : 0;
         done  = (m_run == LockCnt);
         m_wd  = m_wd + 1;
         if (done && m_stage == 2) begin
            m_stage = 3; m_run = 0; m_wd = 0;
         end
`ifdef LOOP_GAIN_SCHEDULER_TIMEOUT_EN
         else if (m_wd == Timeout) begin
            m_stage = 1; m_clr = 1; m_run = 0; m_wd = 0;
         end
`endif
         else if (done) begin
            m_stage = 2; m_run = 0;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_state"}, int'(state_o), m_stage);
      check({tag, "_kp"}, int'(kp_shift_o), kp_tab[m_stage]);
      check({tag, "_ki"}, int'(ki_shift_o), ki_tab[m_stage]);
      check({tag, "_clr"}, int'(integ_clr_o), m_clr);
      check({tag, "_lock"}, int'(lock_o), (m_stage == 3) ? 1 : 0);
   endtask

   // Drive inputs, take one edge in DUT and model, compare 1 ns later.
   task automatic step(input bit en, input int e, input string tag);
      enable_i = en;
      error_i  = e[7:0];
      @(posedge gen_clk_i);
      model_edge(en, e);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int clr_seen;
      int total;
      int len;
      int cls;
      int e;
      bit en;

      reset_i  = 1'b1;
      enable_i = 1'b0;
      error_i  = '0;
      model_reset();
      #12;
      check_outputs("reset");
      reset_i = 1'b0;

      // Constant zero error from reset release
      step(1'b1, 0, "acq_entry");
      check("acq_entry_pulse", int'(integ_clr_o), 1);
      repeat (15) step(1'b1, 0, "acq_run");
      check("acq_before_settle", int'(state_o), 1);
      step(1'b1, 0, "acq_to_settle");
      check("settle_reached", int'(state_o), 2);
      repeat (16) step(1'b1, 0, "settle_run");
      check("track_reached", int'(state_o), 3);
      check("track_lock", int'(lock_o), 1);
      check("track_kp", int'(kp_shift_o), 2);
      check("track_ki", int'(ki_shift_o), 3);

      // Interrupted out-of-lock burst, then a full one
      repeat (3) step(1'b1, -40, "unlock_burst1");
      step(1'b1, 0, "unlock_break");
      repeat (3) step(1'b1, -40, "unlock_burst2");
      check("unlock_hold_track", int'(state_o), 3);
      step(1'b1, -40, "unlock_fire");
      check("unlock_to_acq", int'(state_o), 1);
      check("unlock_pulse", int'(integ_clr_o), 1);

      // Window run broken by one out-of-window sample
      step(1'b1, 5, "window_gap0");
      repeat (15) step(1'b1, 3, "window_run1");
      step(1'b1, 5, "window_gap");
      repeat (15) step(1'b1, 3, "window_run2");
      check("window_still_acq", int'(state_o), 1);
      step(1'b1, 3, "window_run2_end");
      check("window_settle", int'(state_o), 2);

      // Disable during SETTLE
      step(1'b0, 0, "disable_settle");
      check("disable_idle", int'(state_o), 0);
      check("disable_pulse", int'(integ_clr_o), 1);
      step(1'b0, 0, "disable_hold");

      // Back-to-back clear events
      step(1'b1, 0, "b2b_a");
      step(1'b0, 0, "b2b_b");
      step(1'b1, 0, "b2b_c");
      check("b2b_third_pulse", int'(integ_clr_o), 1);

      // Most negative code is out-of-lock, never in-window
      repeat (10) step(1'b1, 3, "minneg_pre");
      step(1'b1, -128, "minneg_acq");
      repeat (15) step(1'b1, 3, "minneg_post");
      check("minneg_no_count", int'(state_o), 1);
      step(1'b1, 0, "minneg_settle");
      repeat (16) step(1'b1, 0, "minneg_to_track");
      repeat (4) step(1'b1, -128, "minneg_track");
      check("minneg_unlock", int'(state_o), 1);

      // Reset mid-acquisition discards progress
      repeat (8) step(1'b1, 0, "midrst_pre");
      #2;
      reset_i = 1'b1;
      model_reset();
      #1;
      check_outputs("midrst_async");
      reset_i = 1'b0;
      step(1'b1, 0, "midrst_entry");
      check("midrst_entry_pulse", int'(integ_clr_o), 1);
      repeat (16) step(1'b1, 0, "midrst_run");
      check("midrst_settle", int'(state_o), 2);

      // Constant mid-range error: watchdog behaviour
      step(1'b0, 0, "wd_idle");
      step(1'b1, 50, "wd_entry");
      clr_seen = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 50, "wd_run");
         clr_seen += int'(integ_clr_o);
      end
`ifdef LOOP_GAIN_SCHEDULER_TIMEOUT_EN
      check("wd_pulses", clr_seen, 3);
`else
      check("wd_pulses", clr_seen, 0);
`endif
      check("wd_state", int'(state_o), 1);

      // Randomized error bursts
      total = 0;
      while (total < 4000) begin
         cls = int'($urandom_range(0, 9));
         len = int'($urandom_range(1, 40));
         for (int i = 0; i < len; i++) begin
            if (cls <= 4) begin
               e = int'($urandom_range(0, 8)) - 4;
            end else if (cls <= 6) begin
               e = int'($urandom_range(5, 32));
               if ($urandom_range(0, 1) == 1) e = -e;
            end else if (cls <= 8) begin
               e = int'($urandom_range(33, 127));
               if ($urandom_range(0, 1) == 1) e = -e;
            end else begin
               e = -128;
            end
            en = ($urandom_range(0, 299) != 0);
            step(en, e, "rand");
            total++;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
